// File: rtl/wb_ram_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of one slave (normally the on-chip RAM).
// Optional strobe watchdog: define ARB_TIMEOUT_EN to abort strobes the slave never answers.

`ifndef ADR_WIDTH
`define ADR_WIDTH 32
`endif
`ifndef DAT_WIDTH
`define DAT_WIDTH 32
`endif

module wb_ram_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [`ADR_WIDTH-1:0] m0_adr_i,
    input  logic [`DAT_WIDTH-1:0] m0_dat_i,
    output logic [`DAT_WIDTH-1:0] m0_dat_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [`ADR_WIDTH-1:0] m1_adr_i,
    input  logic [`DAT_WIDTH-1:0] m1_dat_i,
    output logic [`DAT_WIDTH-1:0] m1_dat_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [`ADR_WIDTH-1:0] s_adr_o,
    output logic [`DAT_WIDTH-1:0] s_dat_o,
    input  logic [`DAT_WIDTH-1:0] s_dat_i,
    input  logic                  s_ack_i,
    input  logic                  s_err_i,
    output logic [1:0]            grant_o
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("wb_ram_arbiter: TIMEOUT_CYCLES must be in 1..65535");
    end

`ifdef ARB_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, ABORT = 2'd2} state_e;
`else
    typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_e;
`endif

    state_e state_q, state_d;
    logic   grant_q, grant_d;   // 0 = m0, 1 = m1
    logic   last_q, last_d;

    logic                  req0, req1;
    logic                  g_cyc, g_stb, g_we;
    logic [`ADR_WIDTH-1:0] g_adr;
    logic [`DAT_WIDTH-1:0] g_dat;
    logic                  ack, err, owned;

    assign req0  = m0_cyc_i & m0_stb_i;
    assign req1  = m1_cyc_i & m1_stb_i;
    assign g_cyc = grant_q ? m1_cyc_i : m0_cyc_i;
    assign g_stb = grant_q ? m1_stb_i : m0_stb_i;
    assign g_we  = grant_q ? m1_we_i  : m0_we_i;
    assign g_adr = grant_q ? m1_adr_i : m0_adr_i;
    assign g_dat = grant_q ? m1_dat_i : m0_dat_i;

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT_CYCLES);
    logic [15:0] wait_cnt_q, wait_cnt_d;

    // Counts only cycles where the granted strobe is outstanding and unanswered.
    always_comb begin
        wait_cnt_d = wait_cnt_q + 16'd1;
        if (state_q != BUSY || !g_stb || s_ack_i || s_err_i) wait_cnt_d = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) wait_cnt_q <= '0;
        else         wait_cnt_q <= wait_cnt_d;
    end
`endif

    // NOTE: every output and next-state variable gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        ack     = 1'b0;
        err     = 1'b0;
        owned   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    grant_d = (req0 && req1) ? ~last_q : req1;
                    last_d  = grant_d;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                owned   = 1'b1;
                s_stb_o = g_stb;
                s_we_o  = g_we;
                s_adr_o = g_adr;
                s_dat_o = g_dat;
                ack     = s_ack_i & g_stb;
                err     = s_err_i & g_stb;
                if (!g_cyc) state_d = IDLE;
`ifdef ARB_TIMEOUT_EN
                else if (wait_cnt_d == TIMEOUT_W) state_d = ABORT;
`endif
            end
`ifdef ARB_TIMEOUT_EN
            ABORT: begin
                // Slave strobe stays low; the master sees err until it withdraws stb.
                owned = 1'b1;
                err   = g_stb;
                if (!g_cyc)      state_d = IDLE;
                else if (!g_stb) state_d = BUSY;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;  // makes m0 win the first tie
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = ack & ~grant_q;
    assign m1_ack_o = ack &  grant_q;
    assign m0_err_o = err & ~grant_q;
    assign m1_err_o = err &  grant_q;
    assign grant_o  = owned ? (grant_q ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Directed self-checking bench for wb_ram_arbiter with a one-wait-state RAM slave model.
// Define ARB_TIMEOUT_EN to also exercise the strobe watchdog (TIMEOUT_CYCLES = 8).

`ifndef ADR_WIDTH
`define ADR_WIDTH 32
`endif
`ifndef DAT_WIDTH
`define DAT_WIDTH 32
`endif

module tb_wb_ram_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]            cyc, stb, we;
    logic [`ADR_WIDTH-1:0] adr [2];
    logic [`DAT_WIDTH-1:0] dat [2];
    logic [`DAT_WIDTH-1:0] m0_rd, m1_rd, s_dat_o, s_dat_i;
    logic [`ADR_WIDTH-1:0] s_adr_o;
    logic                  m0_ack, m1_ack, m0_err, m1_err;
    logic                  s_stb_o, s_we_o, s_ack;
    logic [1:0]            grant_o;
    logic [1:0]            m_ack;

    int checks = 0;
    int errors = 0;

    assign m_ack = {m1_ack, m0_ack};

    wb_ram_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_adr_i(adr[0]), .m0_dat_i(dat[0]),
        .m0_dat_o(m0_rd), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_adr_i(adr[1]), .m1_dat_i(dat[1]),
        .m1_dat_o(m1_rd), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack), .s_err_i(1'b0),
        .grant_o(grant_o)
    );

    // RAM slave: ack one cycle after stb; unwritten words read as A5A500<adr>.
    logic [`DAT_WIDTH-1:0] mem   [256];
    logic                  mem_v [256];
    logic                  slave_en;

    assign s_dat_i = (mem_v[s_adr_o[7:0]] === 1'b1) ? mem[s_adr_o[7:0]]
                                                    : (32'hA5A5_0000 | {24'h0, s_adr_o[7:0]});

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) s_ack <= 1'b0;
        else begin
            s_ack <= s_stb_o & ~s_ack & slave_en;
            if (s_stb_o && s_we_o && !s_ack && slave_en) begin
                mem[s_adr_o[7:0]]   <= s_dat_o;
                mem_v[s_adr_o[7:0]] <= 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int m, input logic on, input logic w, input logic [`ADR_WIDTH-1:0] a,
                           input logic [`DAT_WIDTH-1:0] d);
        cyc[m] = on; stb[m] = on; we[m] = w; adr[m] = a; dat[m] = d;
    endtask

    // Advances cycle by cycle until master m is acked; the other master must never see an ack.
    task automatic wait_ack(input int m);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checks++;
            if (m_ack[1-m] !== 1'b0) begin
                errors++;
                $display("FAIL stray_ack m%0d: got %b want 0 (grant_o=%b)", 1-m, m_ack[1-m], grant_o);
            end
            if (m_ack[m] === 1'b1) return;
        end
        errors++;
        $display("FAIL ack_timeout m%0d: got no ack want ack within 16 cycles", m);
    endtask

    task automatic wait_grant(input logic [1:0] exp);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (grant_o !== 2'b00) break;
        end
        checks++;
        if (grant_o !== exp) begin
            errors++;
            $display("FAIL grant: got %b want %b", grant_o, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        slave_en = 1'b1;
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        step();
        @(negedge clk);
        checks++;
        if ({s_stb_o, s_we_o, grant_o, m_ack, m0_err, m1_err} !== 8'b0) begin
            errors++;
            $display("FAIL reset_outputs: got stb=%b we=%b grant=%b ack=%b want all 0",
                     s_stb_o, s_we_o, grant_o, m_ack);
        end
        checks++;
        if (s_adr_o !== '0 || s_dat_o !== '0) begin
            errors++;
            $display("FAIL reset_bus: got adr=%h dat=%h want 0", s_adr_o, s_dat_o);
        end
        rst_n = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if (grant_o !== 2'b00 || s_stb_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req: got grant=%b stb=%b want 00/0", grant_o, s_stb_o);
        end
    endtask

    task automatic test_write_read();
        do_reset();
        step();
        set_req(0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
        @(negedge clk);
        checks++;
        if (s_stb_o !== 1'b0) begin
            errors++;
            $display("FAIL latency_idle: got s_stb_o=%b want 0", s_stb_o);
        end
        @(negedge clk);
        checks++;
        if ({s_stb_o, s_we_o, grant_o} !== 4'b1101 || s_adr_o !== 32'h10 || s_dat_o !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL write_fwd: got stb=%b we=%b grant=%b adr=%h dat=%h want 1/1/01/10/deadbeef",
                     s_stb_o, s_we_o, grant_o, s_adr_o, s_dat_o);
        end
        wait_ack(0);
        step();
        we[0] = 1'b0;
        wait_ack(0);
        checks++;
        if (m0_rd !== 32'hDEAD_BEEF || grant_o !== 2'b01) begin
            errors++;
            $display("FAIL readback: got dat=%h grant=%b want deadbeef/01", m0_rd, grant_o);
        end
        step();
        set_req(0, 1'b0, 1'b0, '0, '0);
        step();
    endtask

    task automatic test_tie();
        do_reset();
        step();
        set_req(0, 1'b1, 1'b0, 32'h20, '0);
        set_req(1, 1'b1, 1'b0, 32'h30, '0);
        wait_grant(2'b01);
        checks++;
        if (s_adr_o !== 32'h20) begin
            errors++;
            $display("FAIL tie_adr: got %h want 20", s_adr_o);
        end
        wait_ack(0);
        step();
        set_req(0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        checks++;
        if (s_stb_o !== 1'b0) begin
            errors++;
            $display("FAIL drop_stb: got %b want 0", s_stb_o);
        end
        @(negedge clk);
        checks++;
        if (grant_o !== 2'b00 || s_stb_o !== 1'b0) begin
            errors++;
            $display("FAIL turnaround_gap: got grant=%b stb=%b want 00/0", grant_o, s_stb_o);
        end
        @(negedge clk);
        checks++;
        if (grant_o !== 2'b10 || s_stb_o !== 1'b1 || s_adr_o !== 32'h30) begin
            errors++;
            $display("FAIL second_grant: got grant=%b stb=%b adr=%h want 10/1/30", grant_o, s_stb_o, s_adr_o);
        end
        wait_ack(1);
        checks++;
        if (m1_rd !== 32'hA5A5_0030) begin
            errors++;
            $display("FAIL m1_read: got %h want a5a50030", m1_rd);
        end
        step();
        set_req(1, 1'b0, 1'b0, '0, '0);
        step();
    endtask

    task automatic test_alternate();
        logic [1:0] exp_g [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        do_reset();
        step();
        set_req(0, 1'b1, 1'b0, 32'h08, '0);
        set_req(1, 1'b1, 1'b0, 32'h09, '0);
        for (int k = 0; k < 6; k++) begin
            int m = k % 2;
            wait_grant(exp_g[k]);
            wait_ack(m);
            step();
            cyc[m] = 1'b0; stb[m] = 1'b0;
            step();
            cyc[m] = 1'b1; stb[m] = 1'b1;
        end
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        step();
        step();
    endtask

    task automatic test_back_to_back();
        logic [`DAT_WIDTH-1:0] exp_d [4] = '{32'hA5A5_0040, 32'hA5A5_0041, 32'hA5A5_0042, 32'hA5A5_0043};
        do_reset();
        step();
        set_req(1, 1'b1, 1'b0, 32'h40, '0);
        step();
        set_req(0, 1'b1, 1'b0, 32'h50, '0);
        for (int k = 0; k < 4; k++) begin
            wait_ack(1);
            checks++;
            if (m1_rd !== exp_d[k] || grant_o !== 2'b10) begin
                errors++;
                $display("FAIL b2b_read%0d: got dat=%h grant=%b want %h/10", k, m1_rd, grant_o, exp_d[k]);
            end
            step();
            if (k == 3) stb[1] = 1'b0;
            else        adr[1] = adr[1] + 1;
        end
        @(negedge clk);
        checks++;
        if (grant_o !== 2'b10) begin
            errors++;
            $display("FAIL hold_on_cyc: got grant=%b want 10", grant_o);
        end
        step();
        cyc[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (grant_o !== 2'b00) begin
            errors++;
            $display("FAIL b2b_gap: got grant=%b want 00", grant_o);
        end
        @(negedge clk);
        checks++;
        if (grant_o !== 2'b01) begin
            errors++;
            $display("FAIL m0_after_b2b: got grant=%b want 01", grant_o);
        end
        wait_ack(0);
        step();
        set_req(0, 1'b0, 1'b0, '0, '0);
        step();
    endtask

    task automatic test_async_reset();
        do_reset();
        step();
        set_req(0, 1'b1, 1'b0, 32'h60, '0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (s_stb_o !== 1'b1 || grant_o !== 2'b01) begin
            errors++;
            $display("FAIL pre_reset_busy: got stb=%b grant=%b want 1/01", s_stb_o, grant_o);
        end
        #1 rst_n = 1'b0;
        set_req(1, 1'b1, 1'b0, 32'h61, '0);
        #1;
        checks++;
        if (s_stb_o !== 1'b0 || grant_o !== 2'b00 || m_ack !== 2'b00) begin
            errors++;
            $display("FAIL async_reset: got stb=%b grant=%b ack=%b want 0/00/00", s_stb_o, grant_o, m_ack);
        end
        #1 rst_n = 1'b1;
        wait_grant(2'b01);
        wait_ack(0);
        step();
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        step();
        step();
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        slave_en = 1'b0;
        step();
        set_req(0, 1'b1, 1'b0, 32'h70, '0);
        @(negedge clk);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            checks++;
            if ({s_stb_o, m0_err} !== 2'b10) begin
                errors++;
                $display("FAIL stall_cycle%0d: got stb=%b err=%b want 1/0", c, s_stb_o, m0_err);
            end
        end
        for (int c = 9; c <= 10; c++) begin
            @(negedge clk);
            checks++;
            if ({s_stb_o, m0_err, m0_ack, grant_o} !== 5'b01001) begin
                errors++;
                $display("FAIL abort_cycle%0d: got stb=%b err=%b ack=%b grant=%b want 0/1/0/01",
                         c, s_stb_o, m0_err, m0_ack, grant_o);
            end
        end
        step();
        set_req(0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        checks++;
        if (m0_err !== 1'b0) begin
            errors++;
            $display("FAIL abort_err_drop: got %b want 0", m0_err);
        end
        @(negedge clk);
        checks++;
        if (grant_o !== 2'b00) begin
            errors++;
            $display("FAIL abort_to_idle: got grant=%b want 00", grant_o);
        end
        slave_en = 1'b1;
        step();
        set_req(1, 1'b1, 1'b0, 32'h71, '0);
        wait_grant(2'b10);
        wait_ack(1);
        step();
        set_req(1, 1'b0, 1'b0, '0, '0);
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_tie();
        test_alternate();
        test_back_to_back();
        test_async_reset();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_ram_arbiter.md
Name: wb_ram_arbiter

Overview:
- Two-master Wishbone arbiter that shares one Wishbone slave, normally the on-chip RAM, between two requesters (e.g. CPU and DMA/loader).
- Grants with round-robin fairness and holds the grant for the whole bus cycle (cyc held).
- Sits between the masters and the RAM slave port in the SoC interconnect.
- Guarantees the slave sees stb low for at least one cycle between different masters' transactions.

Parameters:
- TIMEOUT_CYCLES, 255: cycles a granted strobe may wait for ack/err before the arbiter aborts it. Used only with ARB_TIMEOUT_EN. Legal range 1..65535.

Ports:
- clk_i  in  1  system clock, all logic on rising edge
- rst_ni  in  1  asynchronous active-low reset
- m0_cyc_i, m1_cyc_i  in  1  master bus-cycle request
- m0_stb_i, m1_stb_i  in  1  master strobe
- m0_we_i, m1_we_i  in  1  master write enable
- m0_adr_i, m1_adr_i  in  `ADR_WIDTH  master address
- m0_dat_i, m1_dat_i  in  `DAT_WIDTH  master write data
- m0_dat_o, m1_dat_o  out  `DAT_WIDTH  read data (s_dat_i broadcast to both)
- m0_ack_o, m1_ack_o  out  1  ack, granted master only
- m0_err_o, m1_err_o  out  1  err, granted master only
- s_stb_o  out  1  strobe to slave
- s_we_o  out  1  write enable to slave
- s_adr_o  out  `ADR_WIDTH  address to slave
- s_dat_o  out  `DAT_WIDTH  write data to slave
- s_dat_i  in  `DAT_WIDTH  slave read data
- s_ack_i  in  1  slave ack
- s_err_i  in  1  slave err
- grant_o  out  2  one-hot current grant: bit0 = m0, bit1 = m1; 00 = none

Behaviour:
- Registers: state {IDLE, BUSY, ABORT}; grant (1 bit, which master); last (1 bit, master granted most recently).
- Reset (rst_ni low, asynchronous):
  - state = IDLE, last = 1 (m0 wins first tie), grant_o = 00.
  - Combinational effect: s_stb_o = 0, s_we_o = 0, s_adr_o = 0, s_dat_o = 0; all m*_ack_o and m*_err_o = 0.
  - Reset asserted mid-transaction drops s_stb_o immediately; the in-flight transfer is abandoned.
- Request: mN_req = mN_cyc_i & mN_stb_i.
- IDLE:
  - Slave outputs are zeroed; grant_o = 00.
  - Only m0 requesting: grant m0. Only m1 requesting: grant m1. Both requesting: grant !last.
  - On a grant: register grant, set last = grant, go to BUSY on the next edge.
  - Grant latency is 1 cycle from request to s_stb_o.
- BUSY:
  - Slave outputs mirror the granted master's stb/we/adr/dat.
  - Granted ack/err = s_ack_i/s_err_i gated by the granted stb. The other master's ack/err = 0.
  - grant_o is one-hot on the granted master.
  - Exit to IDLE when the granted cyc_i goes low. The one IDLE cycle gives the slave the stb-low gap it needs to leave its phase-end state.
  - Stb toggling while cyc stays high keeps the grant: back-to-back transfers by one master are not interrupted.
  - The non-granted master waits; its requests are never lost, only delayed.
- Simultaneous events:
  - Granted cyc drops in the same cycle the other master requests: go to IDLE, then grant the other master one cycle later (2-cycle turnaround).
  - Both masters continuously requesting with cyc drops between cycles: grants strictly alternate.
- s_err_i is passed through unmodified. The arbiter never retries.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Enabled:
  - 16-bit wait counter clears on reset, on s_ack_i/s_err_i, when the granted stb is low, and outside BUSY. Otherwise it increments each BUSY cycle.
  - When the counter reaches TIMEOUT_CYCLES: go to ABORT.
  - ABORT: s_stb_o = 0. Granted mN_err_o = mN_stb_i (held while stb high), ack = 0.
  - Leave ABORT to BUSY when the granted stb goes low with cyc still high, or to IDLE when cyc goes low.
- Disabled: no counter and no ABORT state. A stalled slave holds the grant indefinitely.

Test Plan:
- After reset, m0 writes 0xDEADBEEF to adr 0x10:
  - s_stb_o rises 1 cycle after the request; m0_ack_o follows the slave ack.
  - A subsequent m0 read returns 0xDEADBEEF; grant_o = 01 throughout.
- m0 and m1 request in the same cycle from reset: m0 is granted first. m0 drops cyc → one IDLE cycle (s_stb_o = 0, grant_o = 00) → m1 granted (grant_o = 10).
- Both masters hold continuous requests for 6 cycles each (each drops cyc after every ack): grant sequence is m0, m1, m0, m1, m0, m1, and m1_ack_o never asserts while grant_o = 01.
- m1 keeps cyc high and issues 4 back-to-back reads while m0 requests: no grant switch until m1 drops cyc; all 4 acks go to m1.
- rst_ni pulsed low mid-BUSY, between clock edges: s_stb_o and grant_o go to 0 without waiting for a clock edge. After release, m0 wins the tie.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8, slave ack tied low:
  - m0_err_o asserts on the 9th cycle of strobe and s_stb_o drops.
  - m0 drops stb/cyc → IDLE; the next m1 request is granted normally.
